memory_management: RTL and testbench

- Dual-port synchronous RAM, 32K x 16 by default, used as the processor's unified instruction/data memory.
- Port A is read/write and serves the datapath load/store path.
- Port B is read-only and serves the fetch/inspection path.
- Both ports share one clock; read data is registered and appears one cycle after the request.

---
 rtl/mem_pkg.sv | 12 +
 rtl/dpram_core.sv | 30 +++
 rtl/memory_management.sv | 77 +++++++
 tb/tb_memory_management.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths and types for the unified instruction/data memory.
// Optional build macro: MEM_COLLISION_FWD_EN (see memory_management.sv).
package mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/dpram_core.sv
// Raw storage array: one synchronous write port, two combinational read taps.
// The taps show pre-edge contents, so registered reads are read-first.
module dpram_core #(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the write-port word on the rising edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/memory_management.sv
// Dual-port RAM top: port A read/write (write-first), port B read-only.
// Optional build macro: MEM_COLLISION_FWD_EN forwards A write data to B on same-address collision.
module memory_management #(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enA,
    input  logic              wenA,
    input  logic              enB,
    input  logic [DATA_W-1:0] WriteDataA,
    input  logic [ADDR_W-1:0] AddressA,
    input  logic [ADDR_W-1:0] AddressB,
    output logic [DATA_W-1:0] ReadDataA,
    output logic [DATA_W-1:0] ReadDataB
);

    logic              write_a;
    logic              collide;
    logic [DATA_W-1:0] tap_a;
    logic [DATA_W-1:0] tap_b;
    logic [DATA_W-1:0] next_b;

    // Writes are blocked while reset is held so no request leaks through.
    assign write_a = enA && wenA && !rst;
    assign collide = write_a && enB && (AddressA == AddressB);

    dpram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .we      (write_a),
        .waddr   (AddressA),
        .wdata   (WriteDataA),
        .raddr_a (AddressA),
        .raddr_b (AddressB),
        .rdata_a (tap_a),
        .rdata_b (tap_b)
    );

    // Select port B's next word: old contents, or A's data when forwarding.
    always_comb begin
        next_b = tap_b;
`ifdef MEM_COLLISION_FWD_EN
        if (collide) begin
            next_b = WriteDataA;
        end
`else
        if (collide) begin
            next_b = tap_b;
        end
`endif
    end

    // Port A output register: write-first, holds when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadDataA <= '0;
        end else if (enA) begin
            ReadDataA <= wenA ? WriteDataA : tap_a;
        end
    end

    // Port B output register: read on enable, holds when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadDataB <= '0;
        end else if (enB) begin
            ReadDataB <= next_b;
        end
    end

endmodule

// File: tb/tb_memory_management.sv
// Directed self-checking bench for memory_management.
// Collision expectation follows MEM_COLLISION_FWD_EN when the bench is built with it.
module tb_memory_management;

    logic        clk;
    logic        rst;
    logic        enA;
    logic        wenA;
    logic        enB;
    logic [15:0] WriteDataA;
    logic [14:0] AddressA;
    logic [14:0] AddressB;
    logic [15:0] ReadDataA;
    logic [15:0] ReadDataB;

    int checks;
    int failures;

    typedef struct {
        logic        en_a;
        logic        wen_a;
        logic        en_b;
        logic [15:0] wdata;
        logic [14:0] addr_a;
        logic [14:0] addr_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

`ifdef MEM_COLLISION_FWD_EN
    localparam logic [15:0] COL_B = 16'h1234;
`else
    localparam logic [15:0] COL_B = 16'h00AA;
`endif

    memory_management dut (
        .clk        (clk),
        .rst        (rst),
        .enA        (enA),
        .wenA       (wenA),
        .enB        (enB),
        .WriteDataA (WriteDataA),
        .AddressA   (AddressA),
        .AddressB   (AddressB),
        .ReadDataA  (ReadDataA),
        .ReadDataB  (ReadDataB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        enA = 1'b0;
        wenA = 1'b0;
        enB = 1'b0;
    endtask

    vec_t vt [12];
    int   sweep_bad;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        idle();
        WriteDataA = '0;
        AddressA = '0;
        AddressB = '0;

        vt[0]  = '{1, 1, 0, 16'h0001, 15'd1, 15'd0, 16'h0001, 16'h0000};
        vt[1]  = '{0, 0, 1, 16'h0000, 15'd0, 15'd1, 16'h0001, 16'h0001};
        vt[2]  = '{1, 1, 0, 16'h00AA, 15'd5, 15'd1, 16'h00AA, 16'h0001};
        vt[3]  = '{1, 1, 1, 16'h1234, 15'd5, 15'd5, 16'h1234, COL_B};
        vt[4]  = '{0, 0, 1, 16'h0000, 15'd5, 15'd5, 16'h1234, 16'h1234};
        vt[5]  = '{0, 0, 0, 16'h0000, 15'd0, 15'd1, 16'h1234, 16'h1234};
        vt[6]  = '{0, 1, 0, 16'hFFFF, 15'd5, 15'd1, 16'h1234, 16'h1234};
        vt[7]  = '{0, 0, 1, 16'h0000, 15'd0, 15'd5, 16'h1234, 16'h1234};
        vt[8]  = '{1, 1, 0, 16'h5555, 15'd9, 15'd0, 16'h5555, 16'h1234};
        vt[9]  = '{1, 0, 1, 16'h0000, 15'd9, 15'd1, 16'h5555, 16'h0001};
        vt[10] = '{1, 0, 1, 16'h0000, 15'd5, 15'd9, 16'h1234, 16'h5555};
        vt[11] = '{1, 0, 0, 16'h0000, 15'd1, 15'd5, 16'h0001, 16'h5555};

        #12;
        chk("reset_a", ReadDataA, 16'h0000);
        chk("reset_b", ReadDataB, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            enA = vt[i].en_a;
            wenA = vt[i].wen_a;
            enB = vt[i].en_b;
            WriteDataA = vt[i].wdata;
            AddressA = vt[i].addr_a;
            AddressB = vt[i].addr_b;
            tick();
            chk($sformatf("vec%0d_a", i), ReadDataA, vt[i].exp_a);
            chk($sformatf("vec%0d_b", i), ReadDataB, vt[i].exp_b);
        end

        sweep_bad = 0;
        for (int i = 1; i <= 32767; i++) begin
            enA = 1'b1;
            wenA = 1'b1;
            AddressA = 15'(i);
            WriteDataA = (i == 32767) ? 16'hBEEF : 16'(i);
            enB = (i >= 2);
            AddressB = 15'(i - 1);
            tick();
            if (i >= 2) begin
                checks++;
                if (ReadDataB !== 16'(i - 1)) begin
                    failures++;
                    sweep_bad++;
                    if (sweep_bad <= 8) begin
                        $display("FAIL sweep_b addr %0d: got %h expected %h",
                                 i - 1, ReadDataB, 16'(i - 1));
                    end
                end
            end
        end

        enA = 1'b1;
        wenA = 1'b0;
        AddressA = 15'h7FFF;
        enB = 1'b1;
        AddressB = 15'h7FFF;
        tick();
        chk("top_a", ReadDataA, 16'hBEEF);
        chk("top_b", ReadDataB, 16'hBEEF);

        enA = 1'b1;
        wenA = 1'b1;
        AddressA = 15'd3;
        WriteDataA = 16'h0003;
        enB = 1'b0;
        tick();
        chk("pre_rst_a", ReadDataA, 16'h0003);

        enA = 1'b1;
        wenA = 1'b1;
        AddressA = 15'd3;
        WriteDataA = 16'hFFFF;
        enB = 1'b1;
        AddressB = 15'd3;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_a", ReadDataA, 16'h0000);
        chk("async_rst_b", ReadDataB, 16'h0000);
        tick();
        chk("hold_rst_a", ReadDataA, 16'h0000);
        chk("hold_rst_b", ReadDataB, 16'h0000);

        rst = 1'b0;
        enA = 1'b1;
        wenA = 1'b0;
        AddressA = 15'd3;
        enB = 1'b1;
        AddressB = 15'd3;
        tick();
        chk("post_rst_a", ReadDataA, 16'h0003);
        chk("post_rst_b", ReadDataB, 16'h0003);

        idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
